// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON permutation sequencer and round datapath.
// The state is five 64-bit words with x0 at index 0 (the most significant word of the packed vector).
package ascon_pack;

    localparam int unsigned NB_ROUNDS_MAX = 12;

    typedef logic [0:4][63:0] type_state;

    typedef enum logic [1:0] {
        P12  = 2'b00,
        P8   = 2'b01,
        P6   = 2'b10,
        PRES = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } fsm_e;

    // Reserved encoding falls back to the full permutation.
    function automatic int unsigned n_rounds(input logic [1:0] mode);
        case (mode_e'(mode))
            P8:      return 8;
            P6:      return 6;
            default: return NB_ROUNDS_MAX;
        endcase
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// Combinational single ASCON round: constant addition, 5-bit S-box layer, linear diffusion.
module ascon_round
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);

    type_state   add_s;
    type_state   sub_s;
    logic [63:0] a [5];
    logic [63:0] b [5];

    always_comb begin : constante_add
        add_s    = state_i;
        add_s[2] = state_i[2] ^ {56'd0, ~round_i, round_i};
    end

    // Bitsliced S-box: input mix, chi-like step, output mix and final inversion of x2.
    always_comb begin : substitution_layer
        a[0] = add_s[0] ^ add_s[4];
        a[1] = add_s[1];
        a[2] = add_s[2] ^ add_s[1];
        a[3] = add_s[3];
        a[4] = add_s[4] ^ add_s[3];

        b[0] = a[0] ^ (~a[1] & a[2]);
        b[1] = a[1] ^ (~a[2] & a[3]);
        b[2] = a[2] ^ (~a[3] & a[4]);
        b[3] = a[3] ^ (~a[4] & a[0]);
        b[4] = a[4] ^ (~a[0] & a[1]);

        sub_s[0] = b[0] ^ b[4];
        sub_s[1] = b[1] ^ b[0];
        sub_s[2] = ~b[2];
        sub_s[3] = b[3] ^ b[2];
        sub_s[4] = b[4];
    end

    always_comb begin : diffusion_layer
        state_o[0] = sub_s[0] ^ rotr64(sub_s[0], 19) ^ rotr64(sub_s[0], 28);
        state_o[1] = sub_s[1] ^ rotr64(sub_s[1], 61) ^ rotr64(sub_s[1], 39);
        state_o[2] = sub_s[2] ^ rotr64(sub_s[2],  1) ^ rotr64(sub_s[2],  6);
        state_o[3] = sub_s[3] ^ rotr64(sub_s[3], 10) ^ rotr64(sub_s[3], 17);
        state_o[4] = sub_s[4] ^ rotr64(sub_s[4],  7) ^ rotr64(sub_s[4], 41);
    end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// ASCON p12/p8/p6 sequencer: loads the state on start, applies one round per clock,
// and pulses done_o for one cycle when the result is in state_o.
module ascon_perm_ctrl
    import ascon_pack::*;
#(
    parameter int unsigned NB_ROUNDS_MAX = ascon_pack::NB_ROUNDS_MAX
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [1:0] mode_i,
    input  type_state  state_i,
    output type_state  state_o,
    output logic [3:0] round_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [3:0] LAST_ROUND = 4'(NB_ROUNDS_MAX - 1);

    fsm_e       fsm_q, fsm_d;
    type_state  state_q, state_d;
    logic [3:0] round_q, round_d;
    type_state  round_out;

    ascon_round u_round (
        .state_i (state_q),
        .round_i (round_q),
        .state_o (round_out)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // DONE accepts a new start directly so back-to-back runs have no idle bubble.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        case (fsm_q)
            S_IDLE: begin
                if (start_i) begin
                    fsm_d   = S_RUN;
                    state_d = state_i;
                    round_d = 4'(NB_ROUNDS_MAX - n_rounds(mode_i));
                end
            end
            S_RUN: begin
                state_d = round_out;
                if (round_q == LAST_ROUND) begin
                    fsm_d = S_DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_DONE: begin
                if (start_i) begin
                    fsm_d   = S_RUN;
                    state_d = state_i;
                    round_d = 4'(NB_ROUNDS_MAX - n_rounds(mode_i));
                end else begin
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    assign state_o = state_q;
    assign round_o = round_q;
    assign busy_o  = (fsm_q == S_RUN);
    assign done_o  = (fsm_q == S_DONE);

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Self-checking bench for ascon_perm_ctrl against a table-driven ASCON permutation model.
module tb_ascon_perm_ctrl;
    import ascon_pack::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    type_state  st_in;
    type_state  st_out;
    logic [3:0] round;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    type_state fixed_st;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    ascon_perm_ctrl #(.NB_ROUNDS_MAX(12)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .start_i (start),
        .mode_i  (mode),
        .state_i (st_in),
        .state_o (st_out),
        .round_o (round),
        .busy_o  (busy),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic int mode_rounds(input logic [1:0] m);
        if (m == 2'b01) return 8;
        if (m == 2'b10) return 6;
        return 12;
    endfunction

    // Column-wise S-box lookup, the reference formulation of the substitution layer.
    function automatic type_state ref_perm(input type_state s, input int n);
        logic [63:0] x [5];
        logic [4:0]  col;
        logic [4:0]  o;
        type_state   r;
        for (int w = 0; w < 5; w++) x[w] = s[w];
        for (int i = 12 - n; i < 12; i++) begin
            x[2] = x[2] ^ 64'((15 - i) * 16 + i);
            for (int b = 0; b < 64; b++) begin
                col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                o   = SBOX[col];
                x[0][b] = o[4]; x[1][b] = o[3]; x[2][b] = o[2]; x[3][b] = o[1]; x[4][b] = o[0];
            end
            x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
            x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
            x[2] = x[2] ^ ror(x[2],  1) ^ ror(x[2],  6);
            x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
            x[4] = x[4] ^ ror(x[4],  7) ^ ror(x[4], 41);
        end
        for (int w = 0; w < 5; w++) r[w] = x[w];
        return r;
    endfunction

    function automatic type_state rand_state();
        type_state s;
        for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; mode = 2'b00; st_in = rand_state();
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (st_out !== '0 || round !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold: state=%h round=%0d busy=%b done=%b, required all zero", st_out, round, busy, done);
            end
        end
        start = 1'b0;
        rst = 1'b0;
        tick();
        tests++;
        if (st_out !== '0 || round !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: state=%h round=%0d busy=%b done=%b, required all zero", st_out, round, busy, done);
        end
    endtask

    task automatic test_perm(input logic [1:0] m, input type_state s, input bit perturb, input string name);
        int         n;
        logic [3:0] exp_r;
        type_state  exp_s;
        n     = mode_rounds(m);
        exp_s = ref_perm(s, n);
        start = 1'b1; mode = m; st_in = s;
        tick();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            exp_r = 4'(12 - n + k);
            tests++;
            if (round !== exp_r || busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL %s_run k=%0d: round=%0d busy=%b done=%b, required round=%0d busy=1 done=0", name, k, round, busy, done, exp_r);
            end
            if (perturb) begin
                mode  = 2'($urandom);
                st_in = rand_state();
            end
            tick();
        end
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || round !== 4'd11) begin
            fails++;
            $display("FAIL %s_done: done=%b busy=%b round=%0d, required done=1 busy=0 round=11", name, done, busy, round);
        end
        tests++;
        if (st_out !== exp_s) begin
            fails++;
            $display("FAIL %s_result: got %h required %h", name, st_out, exp_s);
        end
        tick();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || round !== 4'd11 || st_out !== exp_s) begin
            fails++;
            $display("FAIL %s_hold: done=%b busy=%b round=%0d state=%h, required idle with result held", name, done, busy, round, st_out);
        end
    endtask

    task automatic test_back_to_back();
        type_state s;
        type_state exp_s;
        int        dones;
        s     = rand_state();
        exp_s = ref_perm(s, 6);
        dones = 0;
        start = 1'b1; mode = 2'b10; st_in = s;
        tick();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 6; k++) begin
                tests++;
                if (round !== 4'(6 + k) || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_run r=%0d k=%0d: round=%0d busy=%b, required round=%0d busy=1", r, k, round, busy, 6 + k);
                end
                if (done === 1'b1) dones++;
                tick();
            end
            if (done === 1'b1) dones++;
            tests++;
            if (done !== 1'b1 || st_out !== exp_s) begin
                fails++;
                $display("FAIL b2b_done r=%0d: done=%b state=%h, required done=1 state=%h", r, done, st_out, exp_s);
            end
            if (r == 1) start = 1'b0;
            tick();
        end
        if (done === 1'b1) dones++;
        tests++;
        if (dones !== 2 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_count: done pulses=%0d busy=%b, required 2 pulses and idle", dones, busy);
        end
    endtask

    task automatic test_async_reset();
        int  waited;
        bool_dummy: begin end
        start = 1'b1; mode = 2'b00; st_in = rand_state();
        tick();
        start = 1'b0;
        waited = 0;
        while (round !== 4'd5 && waited < 20) begin
            tick();
            waited++;
        end
        tests++;
        if (round !== 4'd5) begin
            fails++;
            $display("FAIL arst_reach: round=%0d after %0d cycles, required 5", round, waited);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (st_out !== '0 || round !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL arst_immediate: state=%h round=%0d busy=%b done=%b, required all zero", st_out, round, busy, done);
        end
        for (int c = 0; c < 14; c++) begin
            tick();
            tests++;
            if (done !== 1'b0 || busy !== 1'b0 || round !== 4'd0) begin
                fails++;
                $display("FAIL arst_hold c=%0d: done=%b busy=%b round=%0d, required zero", c, done, busy, round);
            end
        end
        #2 rst = 1'b0;
        tick();
        tests++;
        if (st_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL arst_release: state=%h busy=%b done=%b, required idle zero", st_out, busy, done);
        end
        test_perm(2'b00, rand_state(), 1'b0, "after_arst");
    endtask

    initial begin
        fixed_st = {64'h00001000808C0001, 64'h6CB10AD9CA912F80, 64'h691AED630E81901F,
                    64'h0C4C36A20853217C, 64'h46487B3E06D9D7A8};
        rst = 1'b1; start = 1'b0; mode = 2'b00; st_in = '0;
        test_reset();
        test_perm(2'b00, fixed_st, 1'b0, "p12");
        test_perm(2'b01, fixed_st, 1'b0, "p8");
        test_perm(2'b10, fixed_st, 1'b0, "p6");
        test_perm(2'b11, fixed_st, 1'b0, "mode11");
        for (int i = 0; i < 6; i++) test_perm(2'($urandom), rand_state(), 1'b0, "rand");
        test_perm(2'b00, fixed_st, 1'b1, "perturb_p12");
        test_perm(2'b01, rand_state(), 1'b1, "perturb_p8");
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ascon_perm_ctrl.md
Name: ascon_perm_ctrl

Overview:
- Sequencer for the ASCON permutation rounds p12/p8/p6. On start it loads a 320-bit state and drives the round index to the constant-addition layer.
- Applies exactly one round (constant add, substitution, diffusion) per clock to a registered state, then signals completion.
- Sits between the mode FSM (initialisation/associated data/plaintext/finalisation) and the round datapath. It is the only owner of the round counter.

Parameters:
- NB_ROUNDS_MAX, 12, total rounds of the full permutation; round index runs 12-N .. 11.

Ports:
- clock_i  in  1  system clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  request to run a permutation; sampled on clock_i
- mode_i  in  2  00: p12, 01: p8, 10: p6, 11: reserved (treated as p12)
- state_i  in  320 (type_state, 5x64)  state loaded on accepted start
- state_o  out  320 (type_state)  registered working state
- round_o  out  4  current round index i fed to constante_add
- busy_o  out  1  high while rounds are being applied
- done_o  out  1  one-cycle pulse: state_o holds the permutation result

Behaviour:
- Reset, async, active-high; all values held while reset_i=1:
  - FSM = IDLE
  - state_o = 0, round_o = 0
  - busy_o = 0, done_o = 0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 → state_q <= state_i; round_q <= 12-N (N=12/8/6 → 0/4/6); FSM <= RUN.
  - Otherwise everything is held.
- RUN:
  - Each edge: state_q <= round(state_q, round_q); round_q <= round_q+1.
  - Applying round 11 → FSM <= DONE; round_q stays at 11, no wrap to 12.
- DONE:
  - done_o=1 for exactly this cycle; state_o is the final result.
  - start_i=1 → load and go to RUN (back-to-back, no idle bubble).
  - Else → IDLE.
- Latency: start sampled at edge E0 → rounds applied at edges E1..EN → done_o high during the cycle after EN. busy_o is high from E0 to EN, i.e. for N cycles.
- Round constant (inside datapath): c = {~i[3:0], i[3:0]}; e.g. i=0 → 0xF0, 4 → 0xB4, 6 → 0x96, 11 → 0x4B.
- start_i while in RUN: ignored. No restart, no queueing; mode_i and state_i are not re-sampled.
- mode_i is sampled only on accepted start. A change mid-run has no effect.
- Reserved mode 11: identical to 00 (12 rounds, round_o starts at 0).
- state_o holds its last value in IDLE until the next accepted start.
- Reset asserted mid-RUN: immediate return to reset values. No done_o pulse; partial state discarded.
- done_o and busy_o are never high in the same cycle.
- round_o is registered; it never exceeds 11.

Decomposition:
- ascon_pack holds:
  - type_state (array of 5 x 64-bit words)
  - mode encodings (P12, P8, P6)
  - constant NB_ROUNDS_MAX
  - FSM state enum
- Sub-module ascon_round: combinational single round. Inputs state_i and round_i; output state_o. Internally chains constante_add → substitution_layer → diffusion_layer.
- ascon_perm_ctrl contains only the FSM, the round counter and the state register, and instantiates one ascon_round.

Test Plan:
- p12 from reset: state_i = {00001000808C0001, 6CB10AD9CA912F80, 691AED630E81901F, 0C4C36A20853217C, 46487B3E06D9D7A8}, mode 00, one-cycle start → round_o = 0,1,…,11 on consecutive cycles; busy_o high 12 cycles; done_o pulses once 13 edges after start; state_o equals the golden-model p12 output.
- p8 and p6: same state_i, mode 01 / 10 → round_o runs 4..11 / 6..11; done_o at edge 9 / 7 after start; state_o matches golden p8 / p6.
- start held high throughout a p6 run → no restart mid-run; new run begins in the DONE cycle (round_o=6 on the next cycle); exactly 2 done pulses for 2 runs.
- reset_i pulsed asynchronously (mid-cycle) at round_o=5 of p12 → outputs go to 0 immediately, without waiting for a clock edge; no done_o; subsequent start runs cleanly from round 0.
- mode 11 → behaviour bit-identical to mode 00: same round_o sequence, same result, same latency.
- mode_i and state_i toggled during RUN → result identical to the unperturbed run.
